// File: rtl/pipe_adder_pkg.sv
// Shared encodings and width helpers for the pipelined adder.
package pipe_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_ACC = 1'b1;

    // Packed width of one stage payload {sum[width:0], ovf}.
    function automatic int unsigned payload_w(int unsigned width);
        return width + 2;
    endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One valid/ready register slice; accepts whenever empty or draining downstream.
module pipe_adder_stage #(
    parameter int unsigned W = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            // Payload only moves on a real transfer so it stays put across bubbles.
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined streaming adder with ADD/ACC ops, optional ACC saturation and an output counter.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned SAT    = 0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf,
    output logic [CNT_W-1:0] out_count
);

    typedef struct packed {
        logic [WIDTH:0] sum;
        logic           ovf;
    } payload_t;

    localparam int unsigned PW = payload_w(WIDTH);

    logic             accept;
    logic [WIDTH:0]   acc_q, acc_d, acc_base;
    logic [WIDTH+1:0] acc_sum;
    payload_t         res;
    payload_t         out_data;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        accept   = in_valid && in_ready;
        acc_base = acc_clr ? '0 : acc_q;
        acc_sum  = {1'b0, acc_base} + {2'b00, a};
        res      = '0;
        if (op == OP_ACC) begin
            res.ovf = acc_sum[WIDTH+1];
            res.sum = ((SAT != 0) && res.ovf) ? '1 : acc_sum[WIDTH:0];
        end else begin
            res.sum = {1'b0, a} + {1'b0, b};
        end
        // Clear lands whether or not anything is accepted; an ACC accept overrides it.
        acc_d = acc_base;
        if (accept && op == OP_ACC) begin
            acc_d = res.sum;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Each slice owns its link signals so the ready chain stays per-stage.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic          s_in_valid;
        logic          s_in_ready;
        logic [PW-1:0] s_in_data;
        logic          s_out_valid;
        logic          s_out_ready;
        logic [PW-1:0] s_out_data;

        if (i == 0) begin : g_first
            assign s_in_valid = in_valid;
            assign s_in_data  = res;
        end else begin : g_mid
            assign s_in_valid = g_stage[i-1].s_out_valid;
            assign s_in_data  = g_stage[i-1].s_out_data;
        end

        if (i == STAGES - 1) begin : g_last
            assign s_out_ready = out_ready;
        end else begin : g_inner
            assign s_out_ready = g_stage[i+1].s_in_ready;
        end

        pipe_adder_stage #(
            .W (PW)
        ) u_stage (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .in_valid_i  (s_in_valid),
            .in_ready_o  (s_in_ready),
            .in_data_i   (s_in_data),
            .out_valid_o (s_out_valid),
            .out_ready_i (s_out_ready),
            .out_data_o  (s_out_data)
        );
    end

    assign in_ready  = g_stage[0].s_in_ready;
    assign out_valid = g_stage[STAGES-1].s_out_valid;
    assign out_data  = g_stage[STAGES-1].s_out_data;
    assign sum       = out_data.sum;
    assign ovf       = out_data.ovf;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: wrap and saturating instances in lockstep against a queue-based model.
module tb_pipe_adder;

    typedef struct packed {
        logic [8:0] s0;
        logic       o0;
        logic [8:0] s1;
        logic       o1;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        op = 1'b0;
    logic        acc_clr = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;

    logic        in_ready, out_valid, ovf;
    logic [8:0]  sum;
    logic [15:0] out_count;
    logic        in_ready_s, out_valid_s, ovf_s;
    logic [8:0]  sum_s;
    logic [15:0] out_count_s;

    int          assert_cnt = 0;
    int          fail_cnt = 0;
    int          exp_cnt = 0;
    logic [8:0]  macc0 = '0;
    logic [8:0]  macc1 = '0;
    bit          last_acc = 1'b0;
    res_t        exp_q[$];
    res_t        got_q[$];

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(8), .STAGES(2), .SAT(0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .acc_clr(acc_clr), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .ovf(ovf), .out_count(out_count)
    );

    pipe_adder #(.WIDTH(8), .STAGES(2), .SAT(1), .CNT_W(16)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .op(op),
        .acc_clr(acc_clr), .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
        .sum(sum_s), .ovf(ovf_s), .out_count(out_count_s)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1);
    end

    // Sample at negedge (scoreboard pop/push), then advance past the next rising edge.
    task automatic tick();
        res_t       e, g;
        logic [9:0] t0, t1;
        logic [8:0] base0, base1;
        @(negedge clk);
        last_acc = 1'b0;
        if (rst_n) begin
            assert_cnt++;
            if (in_ready_s !== in_ready || out_valid_s !== out_valid) begin
                fail_cnt++;
                $display("FAIL lockstep: sat rdy/vld=%b%b, required %b%b",
                         in_ready_s, out_valid_s, in_ready, out_valid);
            end
            if (out_valid && out_ready) begin
                g = '{sum, ovf, sum_s, ovf_s};
                got_q.push_back(g);
                exp_cnt++;
                assert_cnt++;
                if (exp_q.size() == 0) begin
                    fail_cnt++;
                    $display("FAIL scoreboard_extra: got sum=%h, required no output", sum);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        fail_cnt++;
                        $display("FAIL scoreboard: got %h/%b %h/%b, required %h/%b %h/%b",
                                 g.s0, g.o0, g.s1, g.o1, e.s0, e.o0, e.s1, e.o1);
                    end
                end
            end
            base0 = acc_clr ? 9'h000 : macc0;
            base1 = acc_clr ? 9'h000 : macc1;
            if (in_valid && in_ready) begin
                last_acc = 1'b1;
                if (op) begin
                    t0 = {1'b0, base0} + {2'b00, a};
                    t1 = {1'b0, base1} + {2'b00, a};
                    e.s0 = t0[8:0];
                    e.o0 = t0[9];
                    e.s1 = t1[9] ? 9'h1FF : t1[8:0];
                    e.o1 = t1[9];
                    base0 = e.s0;
                    base1 = e.s1;
                end else begin
                    e.s0 = {1'b0, a} + {1'b0, b};
                    e.o0 = 1'b0;
                    e.s1 = e.s0;
                    e.o1 = 1'b0;
                end
                exp_q.push_back(e);
            end
            macc0 = base0;
            macc1 = base1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        assert_cnt++;
        if (out_valid !== 1'b0 || sum !== 9'h000 || ovf !== 1'b0 || out_count !== 16'd0) begin
            fail_cnt++;
            $display("FAIL reset_state: got vld=%b sum=%h ovf=%b cnt=%0d, required 0 0 0 0",
                     out_valid, sum, ovf, out_count);
        end
        rst_n = 1'b1;
        tick();
        assert_cnt++;
        if (in_ready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_add_latency();
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = 1'b0;
        a = 8'hFF;
        b = 8'h01;
        tick();
        in_valid = 1'b0;
        assert_cnt++;
        if (out_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL add_early: got out_valid=%b one edge after accept, required 0", out_valid);
        end
        tick();
        assert_cnt++;
        if (out_valid !== 1'b1 || sum !== 9'h100 || ovf !== 1'b0) begin
            fail_cnt++;
            $display("FAIL add_result: got vld=%b sum=%h ovf=%b, required 1 100 0",
                     out_valid, sum, ovf);
        end
        tick();
        assert_cnt++;
        if (out_count !== 16'd1) begin
            fail_cnt++;
            $display("FAIL add_count: got %0d, required 1", out_count);
        end
    endtask

    task automatic test_acc_stream();
        res_t want[3];
        want[0] = '{9'h0FF, 1'b0, 9'h0FF, 1'b0};
        want[1] = '{9'h1FE, 1'b0, 9'h1FE, 1'b0};
        want[2] = '{9'h0FD, 1'b1, 9'h1FF, 1'b1};
        out_ready = 1'b1;
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        got_q.delete();
        in_valid = 1'b1;
        op = 1'b1;
        a = 8'hFF;
        repeat (3) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && got_q.size() < 3; i++) tick();
        assert_cnt++;
        if (got_q.size() != 3) begin
            fail_cnt++;
            $display("FAIL acc_stream_count: got %0d results, required 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                assert_cnt++;
                if (got_q[i] !== want[i]) begin
                    fail_cnt++;
                    $display("FAIL acc_stream[%0d]: got %h/%b %h/%b, required %h/%b %h/%b", i,
                             got_q[i].s0, got_q[i].o0, got_q[i].s1, got_q[i].o1,
                             want[i].s0, want[i].o0, want[i].s1, want[i].o1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        out_ready = 1'b0;
        op = 1'b0;
        got_q.delete();
        for (int c = 0; c < 5; c++) begin
            in_valid = (n < 4);
            a = 8'(n + 1);
            b = 8'(n + 1);
            tick();
            if (last_acc) n++;
            if (c >= 2) begin
                assert_cnt++;
                if (out_valid !== 1'b1 || sum !== 9'd2 || in_ready !== 1'b0) begin
                    fail_cnt++;
                    $display("FAIL stall_hold[%0d]: got vld=%b sum=%h rdy=%b, required 1 002 0",
                             c, out_valid, sum, in_ready);
                end
            end
        end
        assert_cnt++;
        if (n != 2) begin
            fail_cnt++;
            $display("FAIL stall_accepts: got %0d, required 2", n);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && !(n == 4 && got_q.size() == 4); c++) begin
            in_valid = (n < 4);
            a = 8'(n + 1);
            b = 8'(n + 1);
            tick();
            if (last_acc) n++;
        end
        in_valid = 1'b0;
        assert_cnt++;
        if (got_q.size() != 4) begin
            fail_cnt++;
            $display("FAIL bp_count: got %0d results, required 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                assert_cnt++;
                if (got_q[i].s0 !== 9'(2 * (i + 1))) begin
                    fail_cnt++;
                    $display("FAIL bp_order[%0d]: got %0d, required %0d", i, got_q[i].s0, 2 * (i + 1));
                end
            end
        end
        assert_cnt++;
        if (out_count !== 16'(exp_cnt)) begin
            fail_cnt++;
            $display("FAIL bp_out_count: got %0d, required %0d", out_count, exp_cnt);
        end
    endtask

    task automatic test_acc_clr();
        out_ready = 1'b1;
        acc_clr = 1'b1;
        in_valid = 1'b0;
        tick();
        acc_clr = 1'b0;
        got_q.delete();
        in_valid = 1'b1;
        op = 1'b1;
        a = 8'h80;
        repeat (2) tick();
        acc_clr = 1'b1;
        a = 8'h05;
        tick();
        acc_clr = 1'b0;
        a = 8'h01;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && got_q.size() < 4; i++) tick();
        assert_cnt++;
        if (got_q.size() != 4) begin
            fail_cnt++;
            $display("FAIL clr_count: got %0d results, required 4", got_q.size());
        end else begin
            assert_cnt++;
            if (got_q[1].s0 !== 9'h100 || got_q[2].s0 !== 9'h005 || got_q[3].s0 !== 9'h006 ||
                got_q[3].s1 !== 9'h006) begin
                fail_cnt++;
                $display("FAIL clr_sums: got %h %h %h, required 100 005 006",
                         got_q[1].s0, got_q[2].s0, got_q[3].s0);
            end
        end
    endtask

    task automatic test_reset_flush();
        bit seen = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = 1'b0;
        a = 8'h03;
        b = 8'h03;
        repeat (2) tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_cnt = 0;
        macc0 = '0;
        macc1 = '0;
        assert_cnt++;
        if (out_valid !== 1'b0 || out_count !== 16'd0 || sum !== 9'h000) begin
            fail_cnt++;
            $display("FAIL flush_async: got vld=%b cnt=%0d sum=%h, required 0 0 000",
                     out_valid, out_count, sum);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        assert_cnt++;
        if (seen) begin
            fail_cnt++;
            $display("FAIL flush_ghost: got out_valid after release, required none");
        end
    endtask

    task automatic test_soak();
        int accepted = 0;
        int cyc = 0;
        while (accepted < 10000 && cyc < 60000) begin
            in_valid = ($urandom_range(3) != 0);
            op = 1'($urandom_range(1));
            acc_clr = ($urandom_range(7) == 0);
            a = 8'($urandom);
            b = 8'($urandom);
            out_ready = ($urandom_range(3) != 0);
            tick();
            if (last_acc) accepted++;
            cyc++;
        end
        assert_cnt++;
        if (accepted < 10000) begin
            fail_cnt++;
            $display("FAIL soak_budget: got %0d accepts, required 10000", accepted);
        end
        in_valid = 1'b0;
        acc_clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) tick();
        assert_cnt++;
        if (exp_q.size() != 0) begin
            fail_cnt++;
            $display("FAIL soak_drain: got %0d outstanding, required 0", exp_q.size());
        end
        assert_cnt++;
        if (out_count !== 16'(exp_cnt) || out_count_s !== 16'(exp_cnt)) begin
            fail_cnt++;
            $display("FAIL soak_count: got %0d/%0d, required %0d", out_count, out_count_s,
                     16'(exp_cnt));
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_acc_stream();
        test_back_to_back();
        test_acc_clr();
        test_reset_flush();
        test_soak();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
